c1541_gcr_shifter: RTL and testbench

Bit-level read/write shifter for the 1541 drive: sits between the track buffer stage (flux pulses in/out, `buff_dout`/`buff_din`/`buff_we`) and the drive VIA port A/CA1/CB2. Recovers a bit clock from flux pulses, assembles GCR bytes, detects SYNC (ten consecutive 1 bits) and raises byte-ready. In write mode it serialises VIA bytes into flux pulses for the track stage.

---
 rtl/c1541_pkg.sv | 10 +
 rtl/c1541_bit_clock.sv | 37 +++
 rtl/c1541_gcr_shifter.sv | 113 +++++++++++
 tb/tb_c1541_gcr_shifter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/c1541_pkg.sv
// c1541_pkg: shared constants and cell-length helper for the 1541 GCR shifter.
package c1541_pkg;
   localparam int   SYNC_BITS  = 10;
   localparam logic MODE_READ  = 1'b1;
   localparam logic MODE_WRITE = 1'b0;
   // Bit cell length in clk cycles: (16 - zone) quarter-cell units of 4, over 4 quarters.
   function automatic logic [15:0] cell_len(input logic [1:0] zone, input int unit);
      return 16'((16 - int'(zone)) * unit);
   endfunction
endpackage

// File: rtl/c1541_bit_clock.sv
// c1541_bit_clock: bit-cell counter with registered flux edge detect and mid-cell resync.
module c1541_bit_clock
   import c1541_pkg::*;
#(
   parameter int CELL_UNIT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_mtr,
   input  logic       i_resync_en,
   input  logic       i_clear,
   input  logic       i_flux,
   input  logic [1:0] i_zone,
   output logic       o_bit_tick,
   output logic       o_flux_edge
);
   logic [15:0] r_cell_cnt;
   logic        r_flux_d, r_edge;
   logic [15:0] w_len;
   assign w_len       = cell_len(i_zone, CELL_UNIT);
   // >= lets a zone change to a shorter cell wrap at once.
   assign o_bit_tick  = i_mtr & ~i_clear & (r_cell_cnt >= w_len - 16'd1);
   assign o_flux_edge = r_edge & i_resync_en & i_mtr & ~i_clear;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_cell_cnt <= '0;
         r_flux_d   <= 1'b0;
         r_edge     <= 1'b0;
      end else begin
         r_flux_d <= i_flux;
         r_edge   <= i_flux & ~r_flux_d;
         if (i_clear) r_cell_cnt <= '0;
         else if (o_flux_edge) r_cell_cnt <= w_len >> 1;
         else if (o_bit_tick) r_cell_cnt <= '0;
         else if (i_mtr) r_cell_cnt <= r_cell_cnt + 16'd1;
      end
endmodule

// File: rtl/c1541_gcr_shifter.sv
// c1541_gcr_shifter: 1541 GCR read/write bit shifter with SYNC detect and byte-ready pulse.
module c1541_gcr_shifter
   import c1541_pkg::*;
#(
   parameter int CELL_UNIT  = 8,
   parameter int BYTE_PULSE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mtr,
   input  logic [1:0] speed_zone,
   input  logic       mode,
   input  logic       soe,
   input  logic       flux_in,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       sync_n,
   output logic       byte_n,
   output logic       wr_flux,
   output logic       wr_en
);
   logic                 r_mode, r_flux_seen, r_sync_n, r_byte_n, r_wr_flux, r_wr_en;
   logic [SYNC_BITS-2:0] r_shreg;
   logic [7:0]           r_wsr, r_dout;
   logic [2:0]           r_bit_cnt;
   logic [15:0]          r_byte_cnt, r_wr_cnt;
   logic                 w_mode_chg, w_read, w_tick, w_edge, w_sync, w_byte, w_wr_bit;
   logic [SYNC_BITS-1:0] w_shreg_next;
   logic [7:0]           w_wsr_cur;
   logic [15:0]          w_wr_len;
   c1541_bit_clock #(.CELL_UNIT(CELL_UNIT)) u_bit_clock (
      .clk         (clk),
      .reset       (reset),
      .i_mtr       (mtr),
      .i_resync_en (w_read),
      .i_clear     (w_mode_chg),
      .i_flux      (flux_in),
      .i_zone      (speed_zone),
      .o_bit_tick  (w_tick),
      .o_flux_edge (w_edge)
   );
   assign w_mode_chg   = mode ^ r_mode;
   assign w_read       = (r_mode == MODE_READ);
   assign w_shreg_next = {r_shreg, r_flux_seen};
   assign w_sync       = &w_shreg_next;
   assign w_wsr_cur    = (r_bit_cnt == 3'd0) ? din : r_wsr;
   assign w_wr_bit     = w_wsr_cur[7];
   assign w_wr_len     = cell_len(speed_zone, CELL_UNIT) >> 2;
   assign w_byte       = w_tick & (r_bit_cnt == 3'd7) & ~(w_read & w_sync);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_mode      <= 1'b0;
         r_flux_seen <= 1'b0;
         r_sync_n    <= 1'b1;
         r_byte_n    <= 1'b1;
         r_wr_flux   <= 1'b0;
         r_wr_en     <= 1'b0;
         r_shreg     <= '0;
         r_wsr       <= '0;
         r_dout      <= '0;
         r_bit_cnt   <= '0;
         r_byte_cnt  <= '0;
         r_wr_cnt    <= '0;
      end else begin
         r_mode  <= mode;
         r_wr_en <= mtr & (mode == MODE_WRITE);
         if (w_mode_chg) begin
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_flux_seen <= 1'b0;
            r_sync_n    <= 1'b1;
            r_wr_flux   <= 1'b0;
            r_wr_cnt    <= '0;
         end else if (!mtr) begin
            r_flux_seen <= 1'b0;
            r_sync_n    <= 1'b1;
            r_wr_flux   <= 1'b0;
            r_wr_cnt    <= '0;
         end else begin
            if (w_read) begin
               r_flux_seen <= w_edge | (r_flux_seen & ~w_tick);
               if (w_tick) begin
                  r_shreg   <= w_shreg_next[SYNC_BITS-2:0];
                  r_sync_n  <= ~w_sync;
                  r_bit_cnt <= w_sync ? 3'd0 : r_bit_cnt + 3'd1;
                  if (w_byte) r_dout <= w_shreg_next[7:0];
               end
            end else begin
               r_sync_n <= 1'b1;
               if (w_tick) begin
                  r_wsr     <= w_wsr_cur << 1;
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
            end
            if (w_tick & ~w_read & w_wr_bit) begin
               r_wr_flux <= 1'b1;
               r_wr_cnt  <= w_wr_len - 16'd1;
            end else if (r_wr_cnt != 16'd0) r_wr_cnt <= r_wr_cnt - 16'd1;
            else r_wr_flux <= 1'b0;
         end
         // Byte-ready runs its full width even if the motor stops meanwhile.
         if (w_byte & soe) begin
            r_byte_n   <= 1'b0;
            r_byte_cnt <= 16'(BYTE_PULSE - 1);
         end else if (r_byte_cnt != 16'd0) r_byte_cnt <= r_byte_cnt - 16'd1;
         else r_byte_n <= 1'b1;
      end
   assign dout    = r_dout;
   assign sync_n  = r_sync_n;
   assign byte_n  = r_byte_n;
   assign wr_flux = r_wr_flux;
   assign wr_en   = r_wr_en;
endmodule

// File: tb/tb_c1541_gcr_shifter.sv
// tb_c1541_gcr_shifter: directed read/write/reset vectors for the 1541 GCR shifter.
module tb_c1541_gcr_shifter;
   logic       clk = 1'b0, reset = 1'b1, mtr = 1'b0, mode = 1'b1, soe = 1'b0, flux_in = 1'b0;
   logic [1:0] speed_zone = 2'd3;
   logic [7:0] din = 8'h00, dout;
   logic       sync_n, byte_n, wr_flux, wr_en;
   int cyc = 0, n_checks = 0, n_fail = 0, last_p = 0;
   int byte_falls = 0, byte_run = 0, byte_w = 0, flux_rises = 0, flux_run = 0, flux_w = 0;
   int byte_fall_cyc [0:255];
   int flux_rise_cyc [0:255];
   logic prev_byte_n = 1'b1, prev_wr_flux = 1'b0;
   c1541_gcr_shifter #(.CELL_UNIT(8), .BYTE_PULSE(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .mtr        (mtr),
      .speed_zone (speed_zone),
      .mode       (mode),
      .soe        (soe),
      .flux_in    (flux_in),
      .din        (din),
      .dout       (dout),
      .sync_n     (sync_n),
      .byte_n     (byte_n),
      .wr_flux    (wr_flux),
      .wr_en      (wr_en)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (prev_byte_n && !byte_n) begin
         if (byte_falls < 256) byte_fall_cyc[byte_falls] = cyc;
         byte_falls++;
         byte_run = 0;
      end
      if (!byte_n) byte_run++;
      else if (!prev_byte_n) byte_w = byte_run;
      prev_byte_n = byte_n;
      if (!prev_wr_flux && wr_flux) begin
         if (flux_rises < 256) flux_rise_cyc[flux_rises] = cyc;
         flux_rises++;
         flux_run = 0;
      end
      if (wr_flux) flux_run++;
      else if (prev_wr_flux) flux_w = flux_run;
      prev_wr_flux = wr_flux;
   end
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask
   // One bit cell of len clk; a 1 is a 4-clk flux pulse at 20+off into the cell.
   task automatic send_bit(input logic b, input int off, input int len);
      step(20 + off);
      if (b) begin
         flux_in = 1'b1;
         last_p  = cyc;
      end
      step(4);
      flux_in = 1'b0;
      step(len - 24 - off);
   endtask
   task automatic send_byte(input logic [7:0] v, input int len, input bit jit);
      for (int i = 7; i >= 0; i--) send_bit(v[i], jit ? int'($urandom_range(40)) - 20 : 0, len);
   endtask
   task automatic send_lead(input int len, input bit jit);
      for (int i = 0; i < 8; i++) send_bit(1'b0, 0, len);
      for (int i = 0; i < 9; i++) send_bit(1'b1, jit ? int'($urandom_range(40)) - 20 : 0, len);
   endtask
   int base, fbase, p10, m;
   initial begin
      step(3);
      reset = 1'b0;
      step(2);
      check("rst_dout", dout, 8'h00);
      check("rst_sync_n", sync_n, 1'b1);
      check("rst_byte_n", byte_n, 1'b1);
      check("rst_wr_flux", wr_flux, 1'b0);
      check("rst_wr_en", wr_en, 1'b0);
      // Zone 3 read, byte-ready disabled.
      mtr = 1'b1;
      step(4);
      send_lead(104, 1'b0);
      check("a_presync", sync_n, 1'b1);
      base = byte_falls;
      send_bit(1'b1, 0, 104);
      check("a_sync", sync_n, 1'b0);
      send_byte(8'h52, 104, 1'b0);
      check("a_dout", dout, 8'h52);
      check("a_sync_end", sync_n, 1'b1);
      check("a_no_byte", byte_falls - base, 0);
      check("a_wr_en", wr_en, 1'b0);
      // Zone 3 read, byte-ready enabled.
      soe = 1'b1;
      send_lead(104, 1'b0);
      check("b_presync", sync_n, 1'b1);
      base = byte_falls;
      send_bit(1'b1, 0, 104);
      p10 = last_p;
      check("b_sync", sync_n, 1'b0);
      send_byte(8'h52, 104, 1'b0);
      check("b_dout", dout, 8'h52);
      check("b_byte_cnt", byte_falls - base, 1);
      check("b_byte_time", byte_fall_cyc[base] - p10, 8 * 104 + 54);
      check("b_byte_width", byte_w, 16);
      // Zone 0 read with +-20 clk jitter.
      speed_zone = 2'd0;
      send_lead(128, 1'b1);
      base = byte_falls;
      send_bit(1'b1, int'($urandom_range(40)) - 20, 128);
      check("c_sync", sync_n, 1'b0);
      send_byte(8'h5B, 128, 1'b1);
      check("c_dout0", dout, 8'h5B);
      check("c_byte0_time", byte_fall_cyc[base] - last_p, 66);
      send_byte(8'h6D, 128, 1'b1);
      check("c_dout1", dout, 8'h6D);
      check("c_byte1_time", byte_fall_cyc[base + 1] - last_p, 66);
      check("c_byte_cnt", byte_falls - base, 2);
      send_bit(1'b0, 0, 128);
      send_bit(1'b1, 0, 128);
      send_bit(1'b0, 0, 128);
      // Switch to zone 2 write mid-byte.
      din = 8'hA5;
      speed_zone = 2'd2;
      mode = 1'b0;
      m = cyc;
      fbase = flux_rises;
      base = byte_falls;
      step(900);
      check("d_wr_en", wr_en, 1'b1);
      check("d_dout_held", dout, 8'h6D);
      check("d_sync_n", sync_n, 1'b1);
      check("d_flux_cnt", flux_rises - fbase, 4);
      check("d_flux_c0", flux_rise_cyc[fbase] - m, 113);
      check("d_flux_c2", flux_rise_cyc[fbase + 1] - m, 113 + 2 * 112);
      check("d_flux_c5", flux_rise_cyc[fbase + 2] - m, 113 + 5 * 112);
      check("d_flux_c7", flux_rise_cyc[fbase + 3] - m, 113 + 7 * 112);
      check("d_flux_width", flux_w, 28);
      check("d_byte_cnt", byte_falls - base, 1);
      check("d_byte_time", byte_fall_cyc[base] - m, 113 + 7 * 112);
      check("d_byte_low", byte_n, 1'b0);
      check("d_flux_high", wr_flux, 1'b1);
      // Asynchronous reset while both pulses are active.
      #2;
      reset = 1'b1;
      #1;
      check("e_byte_n", byte_n, 1'b1);
      check("e_wr_flux", wr_flux, 1'b0);
      check("e_dout", dout, 8'h00);
      check("e_sync_n", sync_n, 1'b1);
      check("e_wr_en", wr_en, 1'b0);
      step(2);
      reset = 1'b0;
      // Motor off mid write pulse.
      din = 8'hFF;
      for (int i = 0; i < 300 && !wr_flux; i++) step(1);
      check("f_flux_start", wr_flux, 1'b1);
      step(5);
      mtr = 1'b0;
      step(2);
      check("f_flux_off", wr_flux, 1'b0);
      check("f_wr_en_off", wr_en, 1'b0);
      check("f_sync_n", sync_n, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
